// File: rtl/stack_pkg.sv
// stack_pkg: active-low/active-high enable constants shared by the stack
package stack_pkg;
    localparam logic Enable_  = 1'b0;
    localparam logic Disable_ = 1'b1;
    localparam logic Enable   = 1'b1;
    localparam logic Disable  = 1'b0;
endpackage

// File: rtl/stack.sv
// stack: multi-lane LIFO with optional overflow headroom beyond DEPTH
// Ports: clk, reset_ (sync, active-high), flush_ (sync, active-low clear),
//        push_/wd (active-low push lanes + data), pop_ (active-low pop lanes),
//        rd/v (top-down read window + valids), busy (no room for a full push)
module stack
    import stack_pkg::*;
#(
    parameter int DATA    = 32,
    parameter int DEPTH   = 16,
    parameter int BUF_EXT = 1,
    parameter int PUSH    = 1,
    parameter int POP     = 1
) (
    input  logic                      clk,
    input  logic                      reset_,
    input  logic                      flush_,
    input  logic [PUSH-1:0]           push_,
    input  logic [PUSH-1:0][DATA-1:0] wd,
    input  logic [POP-1:0]            pop_,
    output logic [POP-1:0][DATA-1:0]  rd,
    output logic [POP-1:0]            v,
    output logic                      busy
);
    localparam int CAP = DEPTH + (BUF_EXT != 0 ? PUSH : 0);
    localparam int CW  = $clog2(CAP + 1);
    localparam int IW  = $clog2(CAP);
    logic [DATA-1:0]          mem [CAP];
    logic [CW-1:0]            count;
    logic [CW-1:0]            next_count;
    logic [PUSH-1:0]          wr_en;
    logic [PUSH-1:0][IW-1:0]  wr_idx;
    int                       np;
    int                       pos;
    // pops drop existing top entries first; surviving pushes stack on top in lane order
    always_comb begin
        np = 0;
        for (int i = 0; i < POP; i++)
            if (pop_[i] == Enable_ && int'(count) > i) np++;
        pos    = int'(count) - np;
        wr_en  = '0;
        wr_idx = '0;
        for (int j = 0; j < PUSH; j++)
            if (push_[j] == Enable_ && pos < CAP) begin
                wr_en[j]  = 1'b1;
                wr_idx[j] = IW'(pos);
                pos++;
            end
        next_count = CW'(pos);
    end
    always_comb begin
        for (int i = 0; i < POP; i++) begin
            v[i]  = int'(count) > i;
            rd[i] = v[i] ? mem[IW'(int'(count) - 1 - i)] : '0;
        end
    end
    assign busy = int'(count) + PUSH > DEPTH;
    always_ff @(posedge clk) begin
        if (reset_ || flush_ == Enable_)
            count <= '0;
        else
            count <= next_count;
    end
    // storage is never cleared; only count decides what is visible
    always_ff @(posedge clk) begin
        if (!reset_ && flush_ == Disable_)
            for (int j = 0; j < PUSH; j++)
                if (wr_en[j]) mem[wr_idx[j]] <= wd[j];
    end
endmodule

// File: tb/tb_stack.sv
// tb_stack: scoreboard bench for stack against a queue-based LIFO model
module tb_stack;
    localparam int CAP = 17;
    logic              clk = 1'b0;
    logic              reset_ = 1'b1;
    logic              flush_ = 1'b1;
    logic [0:0]        push_ = 1'b1;
    logic [0:0][31:0]  wd = '0;
    logic [0:0]        pop_ = 1'b1;
    logic [0:0][31:0]  rd;
    logic [0:0]        v;
    logic              busy;
    int                n_checks = 0;
    int                n_fail = 0;
    logic [31:0]       model [$];
    logic [33:0]       exp_q [$];
    string             tag_q [$];

    stack dut (
        .clk(clk), .reset_(reset_), .flush_(flush_), .push_(push_),
        .wd(wd), .pop_(pop_), .rd(rd), .v(v), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input bit rst, input bit fl, input bit ps, input logic [31:0] d,
                       input bit pp, input string tag);
        logic [33:0] e;
        string       t;
        reset_ = rst;
        flush_ = !fl;
        push_  = !ps;
        wd     = d;
        pop_   = !pp;
        if (rst || fl)
            model.delete();
        else begin
            if (pp && model.size() > 0) void'(model.pop_back());
            if (ps && model.size() < CAP) model.push_back(d);
        end
        exp_q.push_back({model.size() > 0, model.size() > 0 ? model[$] : 32'h0,
                         model.size() + 1 > 16});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check({t, ".v"}, 32'(v[0]), 32'(e[33]));
        check({t, ".rd"}, rd[0], e[32:1]);
        check({t, ".busy"}, 32'(busy), 32'(e[0]));
    endtask

    initial begin
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0, "reset");
        cyc(0, 0, 0, 0, 0, "idle_after_reset");
        cyc(0, 0, 1, 32'hdeadbeef, 0, "push_deadbeef");
        cyc(0, 0, 0, 0, 1, "pop_one");
        cyc(0, 0, 0, 0, 1, "pop_empty");
        cyc(0, 0, 1, 32'h1, 0, "push1");
        cyc(0, 0, 1, 32'h2, 0, "push2");
        cyc(0, 0, 1, 32'h3, 0, "push3");
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, "pop_seq");
        for (int i = 0; i < 16; i++) cyc(0, 0, 1, 32'h100 + 32'(i), 0, "fill");
        cyc(0, 0, 1, 32'h200, 0, "push_ext");
        cyc(0, 0, 1, 32'h300, 0, "push_drop");
        cyc(0, 0, 0, 0, 1, "pop_after_drop");
        cyc(0, 0, 0, 0, 1, "pop_below_cap");
        cyc(0, 1, 1, 32'h400, 1, "flush");
        cyc(0, 0, 1, 32'ha, 0, "push_a");
        cyc(0, 0, 1, 32'hb, 1, "push_pop_same");
        cyc(0, 0, 0, 0, 1, "pop_b");
        cyc(0, 0, 1, 32'h55, 0, "push_pre_reset");
        cyc(1, 0, 1, 32'h66, 1, "reset_mid");
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 60) == 0, $urandom_range(0, 40) == 0,
                $urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 2) == 0, "random");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
